// File: rtl/enc16.sv
// enc16: registered 16-to-4 one-hot encoder with valid/ready handshake, hot-count flags and saturating error count
module enc16 #(
  parameter int CNT_W     = 8,
  parameter bit PRIO_HIGH = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      onehot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       code,
  output logic             zero_hot,
  output logic             multi_hot,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_err
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
  state_t           state_q, state_d;
  logic [3:0]       code_q, code_d, idx;
  logic             zero_hot_q, zero_hot_d, multi_hot_q, multi_hot_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [4:0]       n;
  logic             acc;
  assign out_valid = state_q == FULL;
  assign in_ready  = !out_valid || out_ready;
  assign acc       = in_valid && in_ready;
  assign code      = code_q;
  assign zero_hot  = zero_hot_q;
  assign multi_hot = multi_hot_q;
  assign err_cnt   = err_cnt_q;
  // running popcount; the first set bit is taken unless the highest one is preferred
  always_comb begin
    n   = '0;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(onehot[i]);
      if (onehot[i] && (PRIO_HIGH || n == 5'd1)) idx = 4'(i);
    end
  end
  // next state, held result and saturating error count (clear wins over increment)
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    zero_hot_d  = zero_hot_q;
    multi_hot_d = multi_hot_q;
    if (acc) begin
      state_d     = FULL;
      code_d      = idx;
      zero_hot_d  = n == 5'd0;
      multi_hot_d = n > 5'd1;
    end else if (out_ready) begin
      state_d = EMPTY;
    end
    err_cnt_d = clr_err ? '0 :
                (acc && n != 5'd1 && err_cnt_q != '1) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      code_q      <= '0;
      zero_hot_q  <= 1'b0;
      multi_hot_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      zero_hot_q  <= zero_hot_d;
      multi_hot_q <= multi_hot_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_enc16.sv
// tb_enc16: scoreboard bench for enc16 in low-priority, high-priority and 2-bit-counter builds
module tb_enc16;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, clr_err = 0;
  logic [15:0] onehot = '0;
  logic ir0, ov0, zh0, mh0, ir1, ov1, zh1, mh1, ir2, ov2, zh2, mh2;
  logic [3:0] cd0, cd1, cd2;
  logic [7:0] ec0, ec1;
  logic [1:0] ec2;
  always #5 clk = ~clk;

  enc16 dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .onehot(onehot),
    .out_valid(ov0), .out_ready(out_ready), .code(cd0), .zero_hot(zh0), .multi_hot(mh0),
    .err_cnt(ec0), .clr_err(clr_err));
  enc16 #(.PRIO_HIGH(1'b1)) dut_h (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .onehot(onehot), .out_valid(ov1), .out_ready(out_ready), .code(cd1), .zero_hot(zh1),
    .multi_hot(mh1), .err_cnt(ec1), .clr_err(clr_err));
  enc16 #(.CNT_W(2)) dut_s (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
    .onehot(onehot), .out_valid(ov2), .out_ready(out_ready), .code(cd2), .zero_hot(zh2),
    .multi_hot(mh2), .err_cnt(ec2), .clr_err(clr_err));

  typedef struct {logic [3:0] cl, ch; logic zh, mh;} exp_t;
  exp_t q[$];
  exp_t me;
  bit m_full;
  int e8, e2;
  int comps = 0, fails = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    comps++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_enc(logic [15:0] w);
    exp_t r;
    r.cl = 0; r.ch = 0;
    for (int i = 0; i < 16; i++) if (w[i]) r.ch = 4'(i);
    for (int i = 15; i >= 0; i--) if (w[i]) r.cl = 4'(i);
    r.zh = w == 16'h0;
    r.mh = $countones(w) > 1;
    return r;
  endfunction

  function automatic logic [15:0] rnd_word();
    int s = $urandom_range(0, 3);
    if (s == 0) return 16'h0;
    if (s == 1) return 16'($urandom);
    return 16'h1 << $urandom_range(0, 15);
  endfunction

  // reference: accept decision, expected result push and error counters
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); m_full = 0; e8 = 0; e2 = 0;
    end else begin
      bit acc;
      bit bad;
      acc = in_valid && (!m_full || out_ready);
      bad = acc && $countones(onehot) != 1;
      if (acc) q.push_back(ref_enc(onehot));
      m_full = acc || (m_full && !out_ready);
      e8 = clr_err ? 0 : (bad && e8 < 255) ? e8 + 1 : e8;
      e2 = clr_err ? 0 : (bad && e2 < 3) ? e2 + 1 : e2;
    end
  end

  // monitor: compare presented results against the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", ir0, !m_full || out_ready);
      chk("in_ready_h", ir1, !m_full || out_ready);
      chk("in_ready_s", ir2, !m_full || out_ready);
      chk("out_valid", ov0, m_full);
      chk("out_valid_h", ov1, m_full);
      chk("out_valid_s", ov2, m_full);
      if (m_full) begin
        if (q.size() == 0) begin
          comps++; fails++;
          $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
        end else begin
          me = q[0];
          chk("code", cd0, me.cl);
          chk("code_h", cd1, me.ch);
          chk("code_s", cd2, me.cl);
          chk("zero_hot", zh0, me.zh);
          chk("zero_hot_h", zh1, me.zh);
          chk("multi_hot", mh0, me.mh);
          chk("multi_hot_h", mh1, me.mh);
          if (out_ready) void'(q.pop_front());
        end
      end
      chk("err_cnt", ec0, e8);
      chk("err_cnt_h", ec1, e8);
      chk("err_cnt_s", ec2, e2);
    end
  end

  task automatic drive(bit v, logic [15:0] w, bit r, bit c = 0);
    @(posedge clk); #1;
    in_valid = v; onehot = w; out_ready = r; clr_err = c;
  endtask

  initial begin
    #12;
    chk("rst_out_valid", ov0, 0);
    chk("rst_code", cd0, 0);
    chk("rst_zero_hot", zh0, 0);
    chk("rst_multi_hot", mh0, 0);
    chk("rst_err_cnt", ec0, 0);
    @(posedge clk); #1 rst_n = 1;
    for (int k = 0; k < 16; k++) drive(1, 16'h1 << k, 1);
    drive(1, 16'h0000, 1);
    drive(1, 16'h8011, 1);
    drive(0, 16'h0, 1);
    @(negedge clk);
    chk("err_after_zero_multi", ec0, 2);
    drive(1, 16'h0008, 1);
    for (int i = 0; i < 5; i++) drive(1, 16'($urandom), 0);
    drive(1, 16'h0020, 1);
    drive(0, 16'h0, 1);
    drive(0, 16'h0, 1, 1);
    for (int i = 0; i < 5; i++) drive(1, 16'h0, 1);
    drive(0, 16'h0, 1);
    @(negedge clk);
    chk("sat_err_cnt_s", ec2, 3);
    drive(1, 16'h0, 1, 1);
    drive(0, 16'h0, 1);
    @(negedge clk);
    chk("clr_err_cnt_s", ec2, 0);
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), rnd_word(), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    drive(1, 16'h0, 1);
    drive(1, 16'h0004, 0);
    drive(0, 16'h0, 0);
    chk("pre_rst_out_valid", ov0, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_out_valid", ov0, 0);
    chk("arst_code", cd0, 0);
    chk("arst_zero_hot", zh0, 0);
    chk("arst_multi_hot", mh0, 0);
    chk("arst_err_cnt", ec0, 0);
    chk("arst_err_cnt_s", ec2, 0);
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 20; i++) drive(1'($urandom_range(0, 1)), rnd_word(), 1'($urandom_range(0, 1)));
    drive(0, 16'h0, 1);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end
endmodule
